// File: rtl/accumulate_bridge.sv
// Host-side bridge for the accumulate kernel: streams a job into the shared array,
// starts the kernel, then drains the in-place prefix sums through a small read FIFO.
module accumulate_bridge #(
    parameter int N      = 1000,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     r_enable,
    input  logic                     w_enable,
    output logic                     controlArr,
    output logic                     controlArrWEnable_a,
    output logic [ADDR_W-1:0]        controlArrAddr_a,
    output logic signed [DATA_W-1:0] controlArrWData_a,
    input  logic signed [DATA_W-1:0] controlArrRData_a,
    output logic                     busy
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(2 * DEPTH + 2) + 1;

    typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_idx;
    logic [ADDR_W-1:0]         r_pop_cnt;
    logic                      r_ctrl;
    logic                      r_we;
    logic [ADDR_W-1:0]         r_addr;
    logic signed [DATA_W-1:0]  r_wdata;
    logic                      r_renable;
    logic                      r_rd_p0;
    logic [RD_LAT-1:0]         r_rd_vld_p;
    logic signed [DATA_W-1:0]  r_fifo [DEPTH];
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [CNT_W-1:0]          r_count;

    logic                      w_s_hs;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_issue;
    logic [OCC_W-1:0]          w_pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_ready             = !rst && (r_state == LOAD);
    assign w_s_hs              = s_valid && s_ready;
    assign busy                = (r_state != LOAD);
    assign controlArr          = r_ctrl;
    assign controlArrWEnable_a = r_we;
    assign controlArrAddr_a    = r_addr;
    assign controlArrWData_a   = r_wdata;
    assign r_enable            = r_renable;
    assign m_valid             = (r_count != '0);
    assign m_data              = m_valid ? r_fifo[r_rd_ptr] : '0;
    assign w_push              = r_rd_vld_p[RD_LAT-1];
    assign w_pop               = m_valid && m_ready;

    // Reads still in the RAM pipe plus words already buffered; a pop this cycle frees a slot.
    always_comb begin
        w_pending = OCC_W'(r_count) + OCC_W'(r_rd_p0);
        for (int k = 0; k < RD_LAT; k++) begin
            w_pending = w_pending + OCC_W'(r_rd_vld_p[k]);
        end
        w_issue = (r_state == DRAIN) && ({1'b0, r_idx} < (ADDR_W + 1)'(N)) &&
                  ((w_pending - OCC_W'(w_pop)) < OCC_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= controlArrRData_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_idx      <= '0;
            r_pop_cnt  <= '0;
            r_ctrl     <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_renable  <= 1'b0;
            r_rd_p0    <= 1'b0;
            r_rd_vld_p <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            // read-valid pipeline matches the RAM latency
            r_rd_vld_p[0] <= r_rd_p0;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_vld_p[k] <= r_rd_vld_p[k-1];
            end
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            case (r_state)
                LOAD: begin
                    r_we <= w_s_hs;
                    if (w_s_hs) begin
                        r_addr  <= r_idx;
                        r_wdata <= s_data;
                        if (r_idx == ADDR_W'(N - 1)) begin
                            r_state <= START;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                // First START cycle lets the last write land; the second carries the kick.
                START: begin
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                    if (!r_renable) begin
                        r_renable <= 1'b1;
                        r_ctrl    <= 1'b0;
                    end else begin
                        r_renable <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_enable) begin
                        r_state   <= DRAIN;
                        r_ctrl    <= 1'b1;
                        r_addr    <= '0;
                        r_rd_p0   <= 1'b1;
                        r_idx     <= ADDR_W'(1);
                        r_pop_cnt <= '0;
                    end
                end
                DRAIN: begin
                    r_rd_p0 <= w_issue;
                    if (w_issue) begin
                        r_addr <= r_idx;
                        r_idx  <= r_idx + 1'b1;
                    end
                    if (w_pop) begin
                        if (r_pop_cnt == ADDR_W'(N - 1)) begin
                            r_state <= LOAD;
                            r_idx   <= '0;
                            r_addr  <= '0;
                            r_rd_p0 <= 1'b0;
                        end else begin
                            r_pop_cnt <= r_pop_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_accumulate_bridge.sv
// Bench for accumulate_bridge: RAM with 2-cycle read latency plus a behavioural kernel,
// expected outputs are running sums of each job's input words.
module tb_accumulate_bridge;
    localparam int N      = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic s_valid, s_ready, m_valid, m_ready;
    logic signed [DATA_W-1:0] s_data, m_data;
    logic r_enable, w_enable, w_kernel, w_spur;
    logic controlArr, controlArrWEnable_a, busy;
    logic [ADDR_W-1:0] controlArrAddr_a;
    logic signed [DATA_W-1:0] controlArrWData_a, controlArrRData_a;

    logic signed [DATA_W-1:0] mem [0:N-1];
    logic [ADDR_W-1:0] ra1;
    int kcnt;
    int renable_total;
    int out_cnt;
    int mr_mode;
    int n_cmp, n_bad;
    logic prev_hold;
    logic signed [DATA_W-1:0] prev_data;
    logic signed [DATA_W-1:0] in_q[$];
    logic signed [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;
    assign w_enable = w_kernel | w_spur;

    accumulate_bridge #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .r_enable(r_enable), .w_enable(w_enable),
        .controlArr(controlArr), .controlArrWEnable_a(controlArrWEnable_a),
        .controlArrAddr_a(controlArrAddr_a), .controlArrWData_a(controlArrWData_a),
        .controlArrRData_a(controlArrRData_a), .busy(busy)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [63:0] psum(input int k);
        logic signed [63:0] acc = 0;
        for (int j = 0; j <= k; j++) acc += mem[j];
        return acc;
    endfunction

    // Array RAM (write when bridge owns it, 2-cycle read) and a kernel that prefix-sums in place.
    always @(posedge clk) begin
        ra1 <= controlArrAddr_a;
        controlArrRData_a <= mem[ra1];
        if (rst) begin
            kcnt <= 0;
            w_kernel <= 1'b0;
        end else begin
            w_kernel <= 1'b0;
            if (controlArr && controlArrWEnable_a) mem[controlArrAddr_a] <= controlArrWData_a;
            if (r_enable) begin
                renable_total <= renable_total + 1;
                for (int k = 0; k < N; k++) mem[k] <= psum(k);
                kcnt <= $urandom_range(3, 10);
            end else if (kcnt != 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) w_kernel <= 1'b1;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mr_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output scoreboard plus hold-stability check while back-pressured.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
                else chk("m_data", m_data, exp_q.pop_front());
                out_cnt <= out_cnt + 1;
            end
            prev_hold <= m_valid && !m_ready;
            prev_data <= m_data;
        end
    end

    task automatic prep(input int kind);
        logic signed [63:0] v, acc;
        int r;
        acc = 0;
        in_q.delete();
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: v = i + 1;
                1: begin r = $urandom; v = r; end
                2: v = 1;
                3: v = 2;
                default: v = -1;
            endcase
            in_q.push_back(v);
            acc += v;
            exp_q.push_back(acc);
        end
    endtask

    task automatic send(input bit rand_valid, input bit spur_load, input bit spur_start);
        int i = 0;
        int g = 0;
        while (i < N && g < 20000) begin
            @(posedge clk); #1;
            w_spur  = spur_load && (i == 300);
            s_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = in_q[i];
            @(negedge clk);
            if (s_valid && s_ready) i++;
            g++;
        end
        chk("load_count", i, N);
        @(posedge clk); #1;
        s_valid = 1'b0;
        w_spur  = spur_start;
        @(negedge clk);
        chk("last_we", controlArrWEnable_a, 1);
        chk("last_addr", controlArrAddr_a, N - 1);
        chk("last_wdata", controlArrWData_a, in_q[N-1]);
        chk("sready_after_load", s_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("renable_high", r_enable, 1);
        chk("ctrl_fall", controlArr, 0);
        @(posedge clk); #1;
        w_spur = 1'b0;
        @(negedge clk);
        chk("renable_once", r_enable, 0);
        chk("ctrl_run", controlArr, 0);
        chk("busy_run", busy, 1);
    endtask

    task automatic collect(input int base_out, input int base_ren);
        int g = 0;
        while ((out_cnt - base_out) < N && g < 40000) begin
            @(negedge clk);
            g++;
        end
        chk("out_count", out_cnt - base_out, N);
        @(negedge clk);
        chk("sready_relaod", s_ready, 1);
        chk("busy_idle", busy, 0);
        chk("mvalid_idle", m_valid, 0);
        chk("renable_pulses", renable_total - base_ren, 1);
        chk("exp_left", exp_q.size(), 0);
    endtask

    initial begin
        int bo, br, g, maxa;
        n_cmp = 0; n_bad = 0; out_cnt = 0; renable_total = 0; mr_mode = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; w_spur = 1'b0; prev_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_ctrl", controlArr, 1);
        chk("rst_we", controlArrWEnable_a, 0);
        chk("rst_addr", controlArrAddr_a, 0);
        chk("rst_wdata", controlArrWData_a, 0);
        chk("rst_renable", r_enable, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sready", s_ready, 1);

        // job 1: 1..N, full rate both sides
        bo = out_cnt; br = renable_total;
        prep(0); send(0, 0, 0); collect(bo, br);

        // job 2: random data, random handshakes, stray w_enable in LOAD and START
        bo = out_cnt; br = renable_total; mr_mode = 1;
        prep(1); send(1, 1, 1); collect(bo, br);
        mr_mode = 0;

        // job 3: consumer stalled at drain start
        bo = out_cnt; br = renable_total;
        prep(0); send(0, 0, 0);
        mr_mode = 2;
        g = 0;
        while (!(controlArr && busy) && g < 200) begin @(negedge clk); g++; end
        chk("drain_start_addr", controlArrAddr_a, 0);
        maxa = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (controlArr && busy && int'(controlArrAddr_a) > maxa) maxa = controlArrAddr_a;
            if (i == RD_LAT) chk("mvalid_early", m_valid, 0);
            if (i == RD_LAT + 1) chk("mvalid_first", m_valid, 1);
        end
        chk("stall_max_addr", maxa, RD_LAT + 1);
        chk("stall_mvalid", m_valid, 1);
        chk("stall_mdata", m_data, 1);
        mr_mode = 0;
        collect(bo, br);

        // job 4: reset in the middle of draining, then a job of ones
        bo = out_cnt;
        prep(1); send(0, 0, 0);
        g = 0;
        while ((out_cnt - bo) < 500 && g < 20000) begin @(negedge clk); g++; end
        chk("reached_500", out_cnt - bo, 500);
        mr_mode = 2;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("midrst_sready", s_ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_ctrl", controlArr, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sready1", s_ready, 1);
        exp_q.delete();
        mr_mode = 0;
        bo = out_cnt; br = renable_total;
        prep(2); send(0, 0, 0); collect(bo, br);

        // jobs 5 and 6 back to back
        bo = out_cnt; br = renable_total;
        prep(3); send(0, 0, 0); collect(bo, br);
        bo = out_cnt; br = renable_total;
        prep(4); send(0, 0, 0); collect(bo, br);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
